// File: rtl/single_port_ram_if.sv
// ---------------------------------------------------------------------------
// single_port_ram_if
//   Groups the data/address/control signals of single_port_ram.
//
//   Signals:
//     data       write data (DATA_WIDTH)
//     read_addr  read address, registered by the RAM on each rising edge
//     write_addr write address
//     we         write enable, active-high
//     q          read data = mem[registered read address]
//
//   Timing contract: there is no valid/ready handshake. The RAM accepts one
//   write (when we=1) and one read-address update on every rising clock
//   edge; q reflects the address presented before the previous edge.
//
//   Modports:
//     master  drives data/read_addr/write_addr/we, observes q
//     slave   the RAM side
// ---------------------------------------------------------------------------
interface single_port_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] q;

    modport master (
        output data,
        output read_addr,
        output write_addr,
        output we,
        input  q
    );

    modport slave (
        input  data,
        input  read_addr,
        input  write_addr,
        input  we,
        output q
    );
endinterface

// File: rtl/single_port_ram.sv
// ---------------------------------------------------------------------------
// single_port_ram
//   Synchronous-write RAM, one write port and one read port, depth
//   2**ADDR_WIDTH words of DATA_WIDTH bits. The read address is registered
//   and q is a combinational lookup at that registered address, giving a
//   one-clock read latency with write-first behaviour on address collision.
//
//   Ports:
//     clk  rising-edge clock for all state
//     rst  asynchronous active-high reset; clears the registered read
//          address (memory contents are preserved) and blocks writes
//     bus  single_port_ram_if.slave: data, read_addr, write_addr, we, q
// ---------------------------------------------------------------------------
module single_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    single_port_ram_if.slave    bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Power-up contents are all zero; reset never touches the array.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [ADDR_WIDTH-1:0] read_addr_reg;

    // Write port. rst is sampled at the edge so that writes are blocked for
    // every edge seen while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && bus.we) begin
            mem[bus.write_addr] <= bus.data;
        end
    end

    // Read address register; updated every edge regardless of we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_addr_reg <= '0;
        end else begin
            read_addr_reg <= bus.read_addr;
        end
    end

    // Looking up after the write lands makes a same-address write visible
    // right after the edge (write-first).
    assign bus.q = mem[read_addr_reg];

endmodule

// File: tb/tb_single_port_ram.sv
// ---------------------------------------------------------------------------
// tb_single_port_ram
//   Directed scenarios followed by randomized traffic, checked against an
//   array-based reference model of the RAM.
// ---------------------------------------------------------------------------
module tb_single_port_ram;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 2 ** AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    single_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] ref_raddr;
    logic [DW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are sampled 1 time unit
    // after the rising edge.
    task automatic drive_cycle(input logic r, input logic w, input logic [AW-1:0] wa,
                               input logic [DW-1:0] d, input logic [AW-1:0] ra,
                               input string tag);
        @(negedge clk);
        rst            = r;
        bus.we         = w;
        bus.write_addr = wa;
        bus.data       = d;
        bus.read_addr  = ra;
        if (r) begin
            ref_raddr = '0;
            #1;
            check({tag, "_rst_q"}, bus.q, ref_mem[0]);
        end
        @(posedge clk);
        if (!r) begin
            if (w) ref_mem[wa] = d;
            ref_raddr = ra;
        end
        exp_q.push_back(ref_mem[ref_raddr]);
        #1;
        check({tag, "_q"}, bus.q, exp_q.pop_front());
        check({tag, "_raddr"}, dut.read_addr_reg, ref_raddr);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_raddr      = '0;
        bus.we         = 1'b0;
        bus.write_addr = '0;
        bus.data       = '0;
        bus.read_addr  = '0;

        #2;
        check("por_raddr", dut.read_addr_reg, 0);
        check("por_q", bus.q, 0);

        // release reset
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h00, "release");

        // address 0 and boundary word
        drive_cycle(1'b0, 1'b1, 6'h00, 8'hAA, 6'h00, "wr0");
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h00, "rd0");
        check("rd0_val", bus.q, 8'hAA);
        drive_cycle(1'b0, 1'b1, 6'h3F, 8'h55, 6'h00, "wr3f");
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h3F, "rd3f");
        check("rd3f_val", bus.q, 8'h55);

        // back-to-back writes then reads
        drive_cycle(1'b0, 1'b1, 6'h01, 8'h11, 6'h3F, "wr1");
        drive_cycle(1'b0, 1'b1, 6'h02, 8'h22, 6'h3F, "wr2");
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h01, "rd1");
        check("rd1_val", bus.q, 8'h11);
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h02, "rd2");
        check("rd2_val", bus.q, 8'h22);

        // simultaneous write/read at different addresses
        drive_cycle(1'b0, 1'b1, 6'h0A, 8'hFF, 6'h00, "wr_rd_diff");
        check("wr_rd_diff_val", bus.q, 8'hAA);
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h0A, "rd0a");
        check("rd0a_val", bus.q, 8'hFF);

        // read-during-write at the same address (write-first)
        drive_cycle(1'b0, 1'b1, 6'h05, 8'h77, 6'h0A, "wr5_old");
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h05, "hold5");
        check("hold5_old", bus.q, 8'h77);
        drive_cycle(1'b0, 1'b1, 6'h05, 8'h3C, 6'h05, "rdw5");
        check("rdw5_new", bus.q, 8'h3C);

        // write disabled
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b0, 1'b0, 6'h01, 8'h99, 6'h01, "we0");
        check("we0_val", bus.q, 8'h11);

        // asynchronous reset mid-cycle with read_addr_reg = 3F
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h3F, "pre_rst");
        #2;
        rst = 1'b1;
        ref_raddr = '0;
        #1;
        check("async_rst_raddr", dut.read_addr_reg, 0);
        check("async_rst_q", bus.q, 8'hAA);
        // write attempted while reset is held must be blocked
        drive_cycle(1'b1, 1'b1, 6'h07, 8'hEE, 6'h07, "rst_wr_blocked");
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h07, "post_rst7");
        check("post_rst7_val", bus.q, 8'h00);
        drive_cycle(1'b0, 1'b0, 6'h00, 8'h00, 6'h3F, "post_rst3f");
        check("post_rst3f_val", bus.q, 8'h55);

        // randomized traffic with occasional reset and address collisions
        for (int n = 0; n < 400; n++) begin
            logic          r;
            logic          w;
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            logic [DW-1:0] d;
            r  = ($urandom_range(0, 39) == 0);
            w  = $urandom_range(0, 1);
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            d  = DW'($urandom);
            drive_cycle(r, w, wa, d, ra, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
